// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select encodings and hazard FSM states.
package hazard_pkg;
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: forwarding source for one ALU operand; EX/MEM has priority over MEM/WB.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  ex_mem_wr_i,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd_i,
    input  logic                  mem_wb_wr_i,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd_i,
    output logic [1:0]            fwd_o
);
    logic ex_hit, wb_hit;
    always_comb begin
        ex_hit = ex_mem_wr_i && ex_mem_rd_i != '0 && ex_mem_rd_i == src_i;
        wb_hit = mem_wb_wr_i && mem_wb_rd_i != '0 && mem_wb_rd_i == src_i;
        fwd_o  = ex_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_REGFILE;
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX-stage forwarding, load-use bubbles and memory-wait freeze
// for the 5-stage pipeline, with saturating stall statistics and a sticky timeout flag.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IfIdRegRs,
    input  logic [REG_ADDR_W-1:0] IfIdRegRt,
    input  logic                  IfIdUsesRt,
    input  logic [REG_ADDR_W-1:0] IdExRegRs,
    input  logic [REG_ADDR_W-1:0] IdExRegRt,
    input  logic                  IdExMemRead,
    input  logic                  ExMemRegWrite,
    input  logic [REG_ADDR_W-1:0] ExMemRegRd,
    input  logic                  ExMemMemAcc,
    input  logic                  MemReady,
    input  logic                  MemWbRegWrite,
    input  logic [REG_ADDR_W-1:0] MemWbRegRd,
    input  logic                  BranchFlush,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  PcWrite,
    output logic                  IfIdWrite,
    output logic                  IfIdFlush,
    output logic                  IdExFlush,
    output logic                  PipeFreeze,
    output logic                  MemTimeout,
    output logic [CNT_W-1:0]      LuStallCnt,
    output logic [CNT_W-1:0]      MemStallCnt
);
    localparam int BW = $clog2(LOAD_LAT + 1);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [BW-1:0]     bub_q, bub_d;
    logic [TW-1:0]     tmo_q;
    logic              tmo_flag_q;
    logic [CNT_W-1:0]  lu_cnt_q, mem_cnt_q;
    logic              lu, mw, freeze, bubble;
    logic [1:0]        fwd_a, fwd_b;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_i(IdExRegRs), .ex_mem_wr_i(ExMemRegWrite), .ex_mem_rd_i(ExMemRegRd),
        .mem_wb_wr_i(MemWbRegWrite), .mem_wb_rd_i(MemWbRegRd), .fwd_o(fwd_a)
    );
    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_i(IdExRegRt), .ex_mem_wr_i(ExMemRegWrite), .ex_mem_rd_i(ExMemRegRd),
        .mem_wb_wr_i(MemWbRegWrite), .mem_wb_rd_i(MemWbRegRd), .fwd_o(fwd_b)
    );

    // The cycle MemReady arrives in MEM_WAIT is evaluated exactly like RUN with no wait pending.
    always_comb begin
        lu = IdExMemRead && IdExRegRt != '0 &&
             (IdExRegRt == IfIdRegRs || (IfIdUsesRt && IdExRegRt == IfIdRegRt));
        mw = ExMemMemAcc && !MemReady;
        state_d = state_q;
        bub_d   = bub_q;
        freeze  = 1'b0;
        bubble  = 1'b0;
        if (state_q == ST_LU_STALL) begin
            if (mw) begin
                freeze  = 1'b1;
                state_d = ST_MEM_WAIT;
            end else begin
                bubble  = 1'b1;
                bub_d   = bub_q - 1'b1;
                state_d = bub_q == BW'(1) ? ST_RUN : ST_LU_STALL;
            end
        end else if (state_q == ST_MEM_WAIT && !MemReady) begin
            freeze = 1'b1;
        end else if (mw) begin
            freeze  = 1'b1;
            state_d = ST_MEM_WAIT;
        end else if (lu) begin
            bubble  = 1'b1;
            bub_d   = BW'(LOAD_LAT - 1);
            state_d = LOAD_LAT > 1 ? ST_LU_STALL : ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        ForwardA    = rst ? FWD_REGFILE : fwd_a;
        ForwardB    = rst ? FWD_REGFILE : fwd_b;
        PipeFreeze  = !rst && freeze;
        PcWrite     = !rst && !freeze && !bubble;
        IfIdWrite   = !rst && !freeze && !bubble;
        IfIdFlush   = rst || (BranchFlush && !freeze);
        IdExFlush   = rst || bubble || (BranchFlush && !freeze);
        MemTimeout  = tmo_flag_q;
        LuStallCnt  = lu_cnt_q;
        MemStallCnt = mem_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            bub_q      <= '0;
            tmo_q      <= '0;
            tmo_flag_q <= 1'b0;
            lu_cnt_q   <= '0;
            mem_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            tmo_q   <= !freeze ? '0 : tmo_q == TW'(MEM_TIMEOUT) ? tmo_q : tmo_q + 1'b1;
            if (freeze && tmo_q >= TW'(MEM_TIMEOUT - 1))
                tmo_flag_q <= 1'b1;
            if (bubble && lu_cnt_q != '1)
                lu_cnt_q <= lu_cnt_q + 1'b1;
            if (freeze && mem_cnt_q != '1)
                mem_cnt_q <= mem_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding, load-use bubbles, memory freeze,
// timeout, reset abort and counter saturation.
module tb_hazard_forward_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IfIdRegRs, IfIdRegRt, IdExRegRs, IdExRegRt, ExMemRegRd, MemWbRegRd;
    logic       IfIdUsesRt, IdExMemRead, ExMemRegWrite, ExMemMemAcc, MemReady;
    logic       MemWbRegWrite, BranchFlush;
    logic [1:0] ForwardA, ForwardB;
    logic       PcWrite, IfIdWrite, IfIdFlush, IdExFlush, PipeFreeze, MemTimeout;
    logic [2:0] LuStallCnt, MemStallCnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    hazard_forward_unit #(.REG_ADDR_W(5), .LOAD_LAT(2), .MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IfIdUsesRt(IfIdUsesRt),
        .IdExRegRs(IdExRegRs), .IdExRegRt(IdExRegRt), .IdExMemRead(IdExMemRead),
        .ExMemRegWrite(ExMemRegWrite), .ExMemRegRd(ExMemRegRd), .ExMemMemAcc(ExMemMemAcc),
        .MemReady(MemReady), .MemWbRegWrite(MemWbRegWrite), .MemWbRegRd(MemWbRegRd),
        .BranchFlush(BranchFlush),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .PcWrite(PcWrite), .IfIdWrite(IfIdWrite),
        .IfIdFlush(IfIdFlush), .IdExFlush(IdExFlush), .PipeFreeze(PipeFreeze),
        .MemTimeout(MemTimeout), .LuStallCnt(LuStallCnt), .MemStallCnt(MemStallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        {IfIdRegRs, IfIdRegRt, IdExRegRs, IdExRegRt, ExMemRegRd, MemWbRegRd} = '0;
        {IfIdUsesRt, IdExMemRead, ExMemRegWrite, ExMemMemAcc, MemReady} = '0;
        {MemWbRegWrite, BranchFlush} = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        ExMemRegWrite = 1'b1; ExMemRegRd = 5'd8; IdExRegRs = 5'd8;
        #1;
        chk("rst_fwda", ForwardA, 2'b00);
        chk("rst_pcwrite", PcWrite, 1'b0);
        chk("rst_ifidwrite", IfIdWrite, 1'b0);
        chk("rst_idexflush", IdExFlush, 1'b1);
        chk("rst_ififlush", IfIdFlush, 1'b1);
        chk("rst_freeze", PipeFreeze, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();
        #2;
        chk("post_rst_lucnt", LuStallCnt, 3'd0);
        chk("post_rst_memcnt", MemStallCnt, 3'd0);
        chk("post_rst_timeout", MemTimeout, 1'b0);
        chk("run_pcwrite", PcWrite, 1'b1);
        chk("run_idexflush", IdExFlush, 1'b0);

        // forwarding: EX/MEM beats MEM/WB
        ExMemRegWrite = 1'b1; ExMemRegRd = 5'd8; MemWbRegWrite = 1'b1; MemWbRegRd = 5'd8;
        IdExRegRs = 5'd8; IdExRegRt = 5'd8;
        #1;
        chk("t1_fwda", ForwardA, 2'b10);
        chk("t1_fwdb", ForwardB, 2'b10);
        ExMemRegRd = 5'd0; MemWbRegRd = 5'd3; IdExRegRs = 5'd0; IdExRegRt = 5'd3;
        #1;
        chk("t2_fwda", ForwardA, 2'b00);
        chk("t2_fwdb", ForwardB, 2'b01);
        MemWbRegWrite = 1'b0;
        #1;
        chk("t2_wb_nowrite", ForwardB, 2'b00);
        ExMemRegRd = 5'd3;
        #1;
        chk("t2_exmem_b", ForwardB, 2'b10);
        ExMemRegWrite = 1'b0;
        #1;
        chk("t2_exmem_nowrite", ForwardB, 2'b00);

        // load-use detection corners (no edges cross while these hold)
        clear_inputs();
        IdExMemRead = 1'b1; IdExRegRt = 5'd6; IfIdRegRs = 5'd1; IfIdRegRt = 5'd6;
        #1;
        chk("lu_rt_unused", PcWrite, 1'b1);
        IdExRegRt = 5'd0; IfIdRegRs = 5'd0;
        #1;
        chk("lu_r0", PcWrite, 1'b1);

        // LOAD_LAT=2 load-use: two bubble cycles
        tick();
        clear_inputs();
        IdExMemRead = 1'b1; IdExRegRt = 5'd5; IfIdRegRs = 5'd5;
        #1;
        chk("t3_c1_pcwrite", PcWrite, 1'b0);
        chk("t3_c1_ifidwrite", IfIdWrite, 1'b0);
        chk("t3_c1_idexflush", IdExFlush, 1'b1);
        tick();
        chk("t3_c2_pcwrite", PcWrite, 1'b0);
        chk("t3_c2_idexflush", IdExFlush, 1'b1);
        tick();
        IdExMemRead = 1'b0;
        #1;
        chk("t3_run_pcwrite", PcWrite, 1'b1);
        chk("t3_run_idexflush", IdExFlush, 1'b0);
        chk("t3_lucnt", LuStallCnt, 3'd2);
        do_reset();

        // memory wait: 3 freeze cycles
        ExMemMemAcc = 1'b1; MemReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_freeze", PipeFreeze, 1'b1);
            chk("t4_pcwrite", PcWrite, 1'b0);
            tick();
        end
        MemReady = 1'b1;
        #1;
        chk("t4_ready_freeze", PipeFreeze, 1'b0);
        chk("t4_ready_pcwrite", PcWrite, 1'b1);
        tick();
        clear_inputs();
        #1;
        chk("t4_memcnt", MemStallCnt, 3'd3);
        chk("t4_nofreeze", PipeFreeze, 1'b0);
        do_reset();

        // memory wait with load-use and branch held: suppressed while frozen
        ExMemMemAcc = 1'b1; IdExMemRead = 1'b1; IdExRegRt = 5'd5; IfIdRegRs = 5'd5;
        BranchFlush = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t4b_freeze", PipeFreeze, 1'b1);
            chk("t4b_idexflush", IdExFlush, 1'b0);
            chk("t4b_ifidflush", IfIdFlush, 1'b0);
            tick();
        end
        chk("t4b_lucnt_frozen", LuStallCnt, 3'd0);
        MemReady = 1'b1;
        #1;
        chk("t4b_rel_freeze", PipeFreeze, 1'b0);
        chk("t4b_rel_idexflush", IdExFlush, 1'b1);
        chk("t4b_rel_ifidflush", IfIdFlush, 1'b1);
        chk("t4b_rel_pcwrite", PcWrite, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("t4b_lucnt", LuStallCnt, 3'd1);
        chk("t4b_memcnt", MemStallCnt, 3'd3);
        do_reset();

        // timeout after 4 freeze cycles, then reset mid-wait
        ExMemMemAcc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_timeout_early", MemTimeout, 1'b0);
        tick();
        chk("t5_timeout", MemTimeout, 1'b1);
        chk("t5_still_frozen", PipeFreeze, 1'b1);
        chk("t5_memcnt", MemStallCnt, 3'd4);
        tick();
        chk("t5_sticky", MemTimeout, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_rst_freeze", PipeFreeze, 1'b0);
        chk("t5_rst_pcwrite", PcWrite, 1'b0);
        chk("t5_rst_idexflush", IdExFlush, 1'b1);
        chk("t5_rst_ifidflush", IfIdFlush, 1'b1);
        tick();
        rst = 1'b0;
        ExMemMemAcc = 1'b0;
        #1;
        chk("t5_clr_timeout", MemTimeout, 1'b0);
        chk("t5_clr_memcnt", MemStallCnt, 3'd0);
        chk("t5_clr_state", PipeFreeze, 1'b0);
        chk("t5_clr_pcwrite", PcWrite, 1'b1);
        do_reset();

        // 9 bubble cycles on a 3-bit counter
        IdExMemRead = 1'b1; IdExRegRt = 5'd5; IfIdRegRs = 5'd5;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_lucnt6", LuStallCnt, 3'd6);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_lucnt_sat", LuStallCnt, 3'd7);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
